// File: rtl/muldiv_div_core_if.sv
// muldiv_div_core_if: start/done handshake, operands and result of the divider core.
interface muldiv_div_core_if #(
  parameter int WIDTH = 32
) ();

  logic             start_i;
  logic             flush_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             sign_a_i;
  logic             sign_b_i;
  logic [5:0]       ab_status_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  // Operand-conditioning side: issues operations and collects results.
  modport master (
    output start_i, flush_i, op_i, dividend_i, divisor_i, sign_a_i, sign_b_i, ab_status_i,
    input  busy_o, done_o, result_o
  );

  // Divider side.
  modport slave (
    input  start_i, flush_i, op_i, dividend_i, divisor_i, sign_a_i, sign_b_i, ab_status_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands arrive as magnitudes (signed ops) or raw values (unsigned ops); the
// original sign bits restore RISC-V signs at the end. One quotient bit per cycle.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  muldiv_div_core_if.slave div_if
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       op_r;
  logic             sign_a_r, sign_b_r;
  logic [WIDTH-1:0] divisor_r, rem_r, quo_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] result_r;

  logic             launch_s, fast_s;
  logic [WIDTH-1:0] fast_result_s, sign_result_s;
  logic [WIDTH:0]   rem_shift_s, sub_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_next_s, quo_next_s;
  logic             signed_op_s;
  logic             unused_bits_s;

  // Two's-complement negation when en is set, pass-through otherwise.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v, input logic en);
    negate = en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Flush in IDLE suppresses a simultaneous start; zero operands skip the iteration.
  assign launch_s    = (state_r == ST_IDLE) && div_if.start_i && !div_if.flush_i;
  assign fast_s      = div_if.ab_status_i[3] | div_if.ab_status_i[0];
  assign signed_op_s = ~op_r[0];

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  assign rem_shift_s = {rem_r, quo_r[WIDTH-1]};
  assign sub_s       = rem_shift_s - {1'b0, divisor_r};
  assign ge_s        = (rem_shift_s >= {1'b0, divisor_r});
  assign rem_next_s  = ge_s ? sub_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
  assign quo_next_s  = {quo_r[WIDTH-2:0], ge_s};

  // Status flags other than A0/B0 and the subtractor carry-out are not needed here.
  assign unused_bits_s = ^{div_if.ab_status_i[5:4], div_if.ab_status_i[2:1], sub_s[WIDTH]};

  // Fast-path result: divide by zero gives all ones / original A, zero dividend gives 0.
  always_comb begin
    fast_result_s = {WIDTH{1'b0}};
    if (div_if.ab_status_i[3]) begin
      if (div_if.op_i[1]) begin
        fast_result_s = negate(div_if.dividend_i, ~div_if.op_i[0] & div_if.sign_a_i);
      end else begin
        fast_result_s = {WIDTH{1'b1}};
      end
    end else begin
      fast_result_s = {WIDTH{1'b0}};
    end
  end

  // Sign fix-up: quotient negated on differing signs, remainder follows the dividend.
  always_comb begin
    sign_result_s = {WIDTH{1'b0}};
    if (op_r[1]) begin
      sign_result_s = negate(rem_r, signed_op_s & sign_a_r);
    end else begin
      sign_result_s = negate(quo_r, signed_op_s & (sign_a_r ^ sign_b_r));
    end
  end

  // Next-state logic for IDLE -> CALC -> SIGN -> DONE -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_s = fast_s ? ST_DONE : ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (div_if.flush_i) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_ONE) begin
          state_s = ST_SIGN;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_SIGN: begin
        if (div_if.flush_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture on launch and the shift/subtract datapath while calculating.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_r      <= 2'b00;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      divisor_r <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            op_r      <= div_if.op_i;
            sign_a_r  <= div_if.sign_a_i;
            sign_b_r  <= div_if.sign_b_i;
            divisor_r <= div_if.divisor_i;
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= div_if.dividend_i;
            cnt_r     <= CNT_INIT;
          end
        end
        ST_CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r - CNT_ONE;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered outputs; result only changes on the way into DONE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_s == ST_CALC) || (state_s == ST_SIGN);
      done_r <= (state_s == ST_DONE);
      if (launch_s && fast_s) begin
        result_r <= fast_result_s;
      end else if ((state_r == ST_SIGN) && !div_if.flush_i) begin
        result_r <= sign_result_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign div_if.busy_o   = busy_r;
  assign div_if.done_o   = done_r;
  assign div_if.result_o = result_r;

endmodule

// File: tb/tb_muldiv_div_core.sv
// tb_muldiv_div_core: directed and random checks of the divider core against a
// RISC-V division reference, with expected results queued at launch.
module tb_muldiv_div_core;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  muldiv_div_core_if #(.WIDTH(32)) div_if ();

  muldiv_div_core #(.WIDTH(32)) u_dut (
    .clk_i   (clk),
    .reset_i (reset),
    .div_if  (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V M-extension division semantics on raw 32-bit operands.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic        ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   ref_model = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      2'b01:   ref_model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   ref_model = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: ref_model = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Operand conditioning as the upstream stage would do it.
  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = ~op[0];
    div_if.op_i        = op;
    div_if.sign_a_i    = a[31];
    div_if.sign_b_i    = b[31];
    div_if.dividend_i  = (sgn && a[31]) ? (~a + 32'd1) : a;
    div_if.divisor_i   = (sgn && b[31]) ? (~b + 32'd1) : b;
    div_if.ab_status_i = {b == 32'hFFFF_FFFF, b == 32'd1, b == 32'd0,
                          a == 32'hFFFF_FFFF, a == 32'd1, a == 32'd0};
  endtask

  task automatic no_done_window(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (div_if.done_o) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  // Launch one op at the next edge, then wait for done with a bounded loop.
  // lat counts edges after the launch edge until done is visible.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input bit pester);
    int lat, busy_n;
    logic [31:0] e;
    logic        got_done;
    drive(op, a, b);
    div_if.start_i = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    div_if.start_i = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!div_if.done_o && lat < 60) begin
      if (div_if.busy_o) busy_n++;
      if (pester && (lat == 5 || lat == 20 || lat == 32)) begin
        drive(2'b00, 32'd9, 32'd3);
        div_if.start_i = 1'b1;
      end else begin
        div_if.start_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    got_done = div_if.done_o;
    check({tag, "_done"}, {31'd0, got_done}, 32'd1);
    e = exp_q.pop_front();
    check({tag, "_result"}, div_if.result_o, e);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), (exp_lat == 0) ? 32'd0 : 32'd33);
    // A start held through the DONE cycle must not launch anything.
    if (pester) begin
      drive(2'b00, 32'd9, 32'd3);
      div_if.start_i = 1'b1;
    end else begin
      div_if.start_i = 1'b0;
    end
    @(negedge clk);
    div_if.start_i = 1'b0;
    check({tag, "_done_pulse"}, {31'd0, div_if.done_o}, 32'd0);
    check({tag, "_hold"}, div_if.result_o, e);
    check({tag, "_idle_busy"}, {31'd0, div_if.busy_o}, 32'd0);
    last_exp = e;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    n_tests  = 0;
    n_fail   = 0;
    last_exp = 32'd0;
    reset    = 1'b1;
    div_if.start_i = 1'b0;
    div_if.flush_i = 1'b0;
    drive(2'b00, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, div_if.busy_o}, 32'd0);
    check("reset_done", {31'd0, div_if.done_o}, 32'd0);
    check("reset_result", div_if.result_o, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic unsigned and signed cases.
    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);

    // Fast paths: divide by zero and zero dividend.
    do_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    do_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0, 1'b0);
    do_op("remu_dead_0", 2'b11, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
    do_op("divu_0_5", 2'b01, 32'd0, 32'd5, 32'd0, 0, 1'b0);
    do_op("rem_0_m3", 2'b10, 32'd0, 32'hFFFF_FFFD, 32'd0, 0, 1'b0);

    // Signed overflow and full-scale unsigned.
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
    do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0);

    // Flush ten edges into a DIVU, then start a fresh op right away.
    drive(2'b01, 32'd1000, 32'd3);
    div_if.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_if.start_i = 1'b0;
    repeat (9) @(negedge clk);
    div_if.flush_i = 1'b1;
    @(negedge clk);
    div_if.flush_i = 1'b0;
    check("flush_busy", {31'd0, div_if.busy_o}, 32'd0);
    check("flush_done", {31'd0, div_if.done_o}, 32'd0);
    check("flush_result", div_if.result_o, last_exp);
    do_op("divu_1000_3", 2'b01, 32'd1000, 32'd3, 32'd333, 33, 1'b0);

    // Reset twenty edges into an op discards it.
    drive(2'b01, 32'd1000, 32'd7);
    div_if.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_if.start_i = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", {31'd0, div_if.busy_o}, 32'd0);
    check("midreset_done", {31'd0, div_if.done_o}, 32'd0);
    check("midreset_result", div_if.result_o, 32'd0);
    reset = 1'b0;
    no_done_window("midreset_no_done", 40);

    // Flush in IDLE wins over a simultaneous start (fast op would otherwise finish).
    drive(2'b01, 32'd10, 32'd0);
    div_if.start_i = 1'b1;
    div_if.flush_i = 1'b1;
    @(negedge clk);
    div_if.start_i = 1'b0;
    div_if.flush_i = 1'b0;
    check("idleflush_done", {31'd0, div_if.done_o}, 32'd0);
    no_done_window("idleflush_no_done", 5);
    check("idleflush_result", div_if.result_o, 32'd0);

    // Start pulses while busy and during DONE are ignored.
    do_op("divu_pester", 2'b01, 32'd1000, 32'd7, 32'd142, 33, 1'b1);
    no_done_window("pester_no_extra_done", 40);

    // Random operations against the reference model.
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i == 0) rb = 32'd0;
      if (i == 1) ra = 32'd0;
      do_op("random", rop, ra, rb, ref_model(rop, ra, rb),
            (ra == 32'd0 || rb == 32'd0) ? 0 : 33, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
